// File: rtl/output_collector_pkg.sv
// Shared defaults and small elaboration helpers for the output deskew collector.
package output_collector_pkg;

  localparam int HIGHT_DEFAULT      = 8;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int DEPTH_DEFAULT      = 16;
  localparam int AF_MARGIN_DEFAULT  = 8;
  localparam int ROWS_DEFAULT       = 8;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Lowest bit of lane `lane` inside a packed row of lanes.
  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// Enable-gated delay line for one result lane (data plus valid).
// LENGTH = 0 is a plain wire.
module lane_delay #(
  parameter int LENGTH     = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  if (LENGTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ enable;
    assign out_data    = in_data;
    assign out_valid   = in_valid;
  end else begin : g_line
    logic [DATA_WIDTH-1:0] data_reg [LENGTH];
    logic [LENGTH-1:0]     valid_reg;

    // Stages hold while the array is frozen so in-flight rows survive a stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= '0;
        for (int k = 0; k < LENGTH; k++) data_reg[k] <= '0;
      end else if (enable) begin
        data_reg[0]  <= in_data;
        valid_reg[0] <= in_valid;
        for (int k = 1; k < LENGTH; k++) begin
          data_reg[k]  <= data_reg[k-1];
          valid_reg[k] <= valid_reg[k-1];
        end
      end
    end

    assign out_data  = data_reg[LENGTH-1];
    assign out_valid = valid_reg[LENGTH-1];
  end

endmodule

// File: rtl/output_deskew_collector.sv
// Realigns the PE array's skewed result lanes into whole rows and queues them
// in a row FIFO drained over valid/ready, with tile-end marking and flow control.
module output_deskew_collector
  import output_collector_pkg::*;
#(
  parameter int HIGHT      = HIGHT_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int AF_MARGIN  = AF_MARGIN_DEFAULT,
  parameter int ROWS       = ROWS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [HIGHT*DATA_WIDTH-1:0] in_data,
  input  logic [HIGHT-1:0]            in_valid,
  output logic [HIGHT*DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        almost_full,
  output logic                        skew_err,
  output logic                        ovf_err
);

  localparam int ROW_W  = HIGHT * DATA_WIDTH;
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TILE_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROW_W-1:0] aligned_data;
  logic [HIGHT-1:0] aligned_valid;

  // Lane i lags lane 0 by i cycles, so it is delayed HIGHT-1-i to line up.
  for (genvar gi = 0; gi < HIGHT; gi++) begin : g_lane
    lane_delay #(
      .LENGTH     (HIGHT - 1 - gi),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_data   (in_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
      .in_valid  (in_valid[gi]),
      .out_data  (aligned_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
      .out_valid (aligned_valid[gi])
    );
  end

  logic [ROW_W-1:0]  mem [DEPTH];
  logic [ROW_W-1:0]  head_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [TILE_W-1:0] tile_cnt_reg;
  logic              skew_err_reg, ovf_err_reg;
  logic              row_full, row_partial, push_req, pop, push_ok, bypass;

  always_comb begin
    row_full    = &aligned_valid;
    row_partial = (|aligned_valid) && !row_full;
    push_req    = enable && row_full;
    pop         = out_valid && out_ready;
    push_ok     = push_req && ((count_reg != CNT_W'(DEPTH)) || pop);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
    // The incoming row becomes the head when nothing else remains queued.
    bypass      = push_ok && ((count_reg - CNT_W'(pop)) == '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= aligned_data;
  end

  // Head row is prefetched one cycle ahead so the RAM read stays registered.
  always_ff @(posedge clk) begin
    head_reg <= bypass ? aligned_data : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tile_cnt_reg <= '0;
      skew_err_reg <= 1'b0;
      ovf_err_reg  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (pop) begin
        if (tile_cnt_reg == TILE_W'(ROWS - 1)) tile_cnt_reg <= '0;
        else                                   tile_cnt_reg <= tile_cnt_reg + TILE_W'(1);
      end
      if (enable && row_partial) skew_err_reg <= 1'b1;
      if (push_req && !push_ok)  ovf_err_reg  <= 1'b1;
    end
  end

  assign out_valid   = (count_reg != '0);
  assign out_data    = head_reg;
  assign out_last    = out_valid && (tile_cnt_reg == TILE_W'(ROWS - 1));
  assign almost_full = (CNT_W'(DEPTH) - count_reg) <= CNT_W'(AF_MARGIN);
  assign skew_err    = skew_err_reg;
  assign ovf_err     = ovf_err_reg;

endmodule

// File: tb/tb_output_deskew_collector.sv
// Directed scenarios with random row data, checked against a row-level queue model.
module tb_output_deskew_collector;

  localparam int H     = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFM   = 8;
  localparam int ROWS  = 8;
  localparam int RW    = H * DW;
  localparam int MAXF  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic [H-1:0]  in_valid = '0;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last, almost_full, skew_err, ovf_err;

  always #5 clk = ~clk;

  output_deskew_collector #(
    .HIGHT(H), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .ROWS(ROWS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .almost_full(almost_full), .skew_err(skew_err), .ovf_err(ovf_err)
  );

  // Input schedule indexed by enabled-cycle number; kind marks the frame where a row completes.
  logic [H-1:0]  fr_valid [MAXF];
  logic [RW-1:0] fr_data  [MAXF];
  int            fr_kind  [MAXF];
  logic [RW-1:0] fr_row   [MAXF];
  int            fidx;

  logic [RW-1:0] mq[$];
  bit            m_skew, m_ovf;
  int            m_pops, dut_pops;
  int            n_checks = 0, n_pass = 0, n_fail = 0;
  logic [RW-1:0] row;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_frames();
    for (int f = 0; f < MAXF; f++) begin
      fr_valid[f] = '0;
      fr_data[f]  = '0;
      fr_kind[f]  = 0;
      fr_row[f]   = '0;
    end
    fidx = 0;
  endtask

  task automatic add_row(input int p, input logic [RW-1:0] r, input int bad_lane);
    int f;
    for (int i = 0; i < H; i++) begin
      f = p + i + ((i == bad_lane) ? 1 : 0);
      fr_valid[f][i]         = 1'b1;
      fr_data[f][i*DW +: DW] = r[i*DW +: DW];
    end
    fr_kind[p+H-1] = (bad_lane >= 0) ? 2 : 1;
    fr_row[p+H-1]  = r;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < H; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic check_outputs();
    check("out_valid", RW'(out_valid), RW'(mq.size() > 0));
    if (mq.size() > 0) check("out_data", out_data, mq[0]);
    check("out_last", RW'(out_last), RW'((mq.size() > 0) && (m_pops % ROWS == ROWS - 1)));
    check("almost_full", RW'(almost_full), RW'((DEPTH - mq.size()) <= AFM));
    check("skew_err", RW'(skew_err), RW'(m_skew));
    check("ovf_err", RW'(ovf_err), RW'(m_ovf));
  endtask

  task automatic step(input bit en, input bit rdy);
    bit            pop, push;
    logic [RW-1:0] nrow;
    enable    = en;
    out_ready = rdy;
    in_valid  = (fidx < MAXF) ? fr_valid[fidx] : '0;
    in_data   = (fidx < MAXF) ? fr_data[fidx]  : '0;
    pop  = rdy && (mq.size() > 0);
    push = 1'b0;
    nrow = '0;
    if (en && fidx < MAXF) begin
      if (fr_kind[fidx] == 1) begin
        if (mq.size() < DEPTH || pop) begin
          push = 1'b1;
          nrow = fr_row[fidx];
        end else m_ovf = 1'b1;
      end else if (fr_kind[fidx] == 2) m_skew = 1'b1;
    end
    #3;
    if (out_valid && out_ready) dut_pops++;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (push) mq.push_back(nrow);
    if (en) fidx++;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    in_valid = '0;
    in_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_skew = 1'b0;
    m_ovf  = 1'b0;
    m_pops = 0;
    clear_frames();
    check_outputs();
  endtask

  task automatic expect_pops(input string tag, input int n);
    check(tag, RW'(dut_pops), RW'(n));
    dut_pops = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dut_pops = 0;
    do_reset();

    // Skewed stream, enable held, consumer always ready.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < H; i++) row[i*DW +: DW] = DW'(r * 16 + i);
      add_row(r, row, -1);
    end
    for (int k = 0; k < 18; k++) step(1'b1, 1'b1);
    expect_pops("stream_rows", 8);

    // Same stream with every third cycle frozen.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < H; i++) row[i*DW +: DW] = DW'(r * 16 + i);
      add_row(r, row, -1);
    end
    for (int k = 0; k < 30; k++) step(k % 3 != 2, 1'b1);
    expect_pops("gap_rows", 8);

    // Full FIFO with a pop on the cycle the 17th row arrives.
    do_reset();
    for (int r = 0; r < 17; r++) add_row(r, rand_row(), -1);
    for (int k = 0; k < 24; k++) step(1'b1, k == 23);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
    expect_pops("full_pop_rows", 17);

    // Backpressure: 17th row without a pop is dropped.
    do_reset();
    for (int r = 0; r < 17; r++) add_row(r, rand_row(), -1);
    for (int k = 0; k < 24; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
    expect_pops("overflow_rows", 16);

    // Lane 3 of the second row arrives one cycle late.
    do_reset();
    add_row(0, rand_row(), -1);
    add_row(1, rand_row(), 3);
    for (int p = 3; p < 7; p++) add_row(p, rand_row(), -1);
    for (int k = 0; k < 18; k++) step(1'b1, 1'b1);
    expect_pops("skew_rows", 5);

    // Reset with five rows queued, then a fresh tile.
    do_reset();
    for (int r = 0; r < 12; r++) add_row(r, rand_row(), -1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    expect_pops("pre_reset_rows", 2);
    do_reset();
    for (int r = 0; r < 10; r++) add_row(r, rand_row(), -1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
    expect_pops("post_reset_rows", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
